hex_word_printer: RTL and testbench

//  Sequences one hex2ascii_df converter to print a multi-nibble word as an ASCII character stream.

---
 rtl/hex_word_printer.sv | 236 +++++++++++++++++++++++
 tb/tb_hex_word_printer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_word_printer.sv
// ----------------------------------------------------------------------------
// hex_word_printer
//   Prints one multi-nibble word as a stream of 7-bit ASCII characters,
//   MSB nibble first, framed by an optional "0x" prefix and an optional
//   '\n' terminator. A single hex2ascii_df converter is time-shared across
//   all digits. Every output is registered, and no combinational path runs
//   from in_* to out_*.
//
// Parameters
//   NIBBLES  hex digits per word (1..16); in_data is 4*NIBBLES bits wide
//   PREFIX   1: emit '0','x' before the digits
//   TERM     1: emit '\n' after the last digit
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   in_valid   in   in_data valid
//   in_ready   out  word can be accepted (high only in IDLE)
//   in_data    in   word to print
//   out_valid  out  out_char valid
//   out_ready  in   sink takes out_char this cycle
//   out_char   out  ASCII character
//   out_last   out  final character of the word
//   busy       out  high in any state other than IDLE
// ----------------------------------------------------------------------------

// Nibble to uppercase ASCII hex digit (pure combinational).
module hex2ascii_df (
    input  logic [3:0] nibble,
    output logic [6:0] ascii_c
);
    always_comb begin
        if (nibble < 4'd10) begin
            ascii_c = 7'(7'h30 + 7'(nibble));
        end else begin
            ascii_c = 7'(7'h37 + 7'(nibble));
        end
    end
endmodule

module hex_word_printer #(
    parameter int unsigned NIBBLES = 8,
    parameter int unsigned PREFIX  = 1,
    parameter int unsigned TERM    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [6:0]             out_char,
    output logic                   out_last,
    output logic                   busy
);

    localparam int unsigned DATA_W = 4 * NIBBLES;
    localparam int unsigned IDX_W  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    localparam logic [6:0] CH_ZERO = 7'h30;
    localparam logic [6:0] CH_X    = 7'h78;
    localparam logic [6:0] CH_LF   = 7'h0A;

    // A digit carries out_last only when no terminator follows it.
    localparam logic LAST_ON_DIGIT = (TERM == 0);
    // The first digit is also the last one for a single-nibble word.
    localparam logic FIRST_IS_LAST = (NIBBLES == 1) && (TERM == 0);

    // State names the character currently presented on out_char.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PFX0  = 3'd1,
        S_PFX1  = 3'd2,
        S_DIGIT = 3'd3,
        S_TERM  = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_n;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_n;
    // Remaining digits, next digit to print always in the top nibble.
    logic [DATA_W-1:0]  r_word;
    logic [DATA_W-1:0]  w_word_n;
    logic               r_out_valid;
    logic               w_out_valid_n;
    logic [6:0]         r_out_char;
    logic [6:0]         w_out_char_n;
    logic               r_out_last;
    logic               w_out_last_n;
    logic               r_in_ready;
    logic               w_in_ready_n;
    logic               r_busy;
    logic               w_busy_n;

    logic               w_fire;
    logic               w_accept;
    logic [3:0]         w_nibble;
    logic [6:0]         w_ascii;

    assign w_fire   = r_out_valid && out_ready;
    assign w_accept = in_valid && r_in_ready;

    // In IDLE the converter looks at the incoming word so the first digit
    // can be registered on the accept edge when there is no prefix.
    always_comb begin
        if (r_state == S_IDLE) begin
            w_nibble = in_data[DATA_W-1 -: 4];
        end else begin
            w_nibble = r_word[DATA_W-1 -: 4];
        end
    end

    hex2ascii_df u_hex2ascii (
        .nibble  (w_nibble),
        .ascii_c (w_ascii)
    );

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_word      <= '0;
            r_out_valid <= 1'b0;
            r_out_char  <= 7'h00;
            r_out_last  <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_idx       <= w_idx_n;
            r_word      <= w_word_n;
            r_out_valid <= w_out_valid_n;
            r_out_char  <= w_out_char_n;
            r_out_last  <= w_out_last_n;
            r_in_ready  <= w_in_ready_n;
            r_busy      <= w_busy_n;
        end
    end

    // Next state and next registered outputs; nothing moves without a fire.
    always_comb begin
        w_state_n     = r_state;
        w_idx_n       = r_idx;
        w_word_n      = r_word;
        w_out_valid_n = r_out_valid;
        w_out_char_n  = r_out_char;
        w_out_last_n  = r_out_last;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_out_valid_n = 1'b1;
                    w_idx_n       = IDX_W'(NIBBLES - 1);
                    if (PREFIX != 0) begin
                        w_state_n    = S_PFX0;
                        w_word_n     = in_data;
                        w_out_char_n = CH_ZERO;
                        w_out_last_n = 1'b0;
                    end else begin
                        w_state_n    = S_DIGIT;
                        w_word_n     = DATA_W'(in_data << 4);
                        w_out_char_n = w_ascii;
                        w_out_last_n = FIRST_IS_LAST;
                    end
                end
            end

            S_PFX0: begin
                if (w_fire) begin
                    w_state_n    = S_PFX1;
                    w_out_char_n = CH_X;
                    w_out_last_n = 1'b0;
                end
            end

            S_PFX1: begin
                if (w_fire) begin
                    w_state_n    = S_DIGIT;
                    w_word_n     = DATA_W'(r_word << 4);
                    w_out_char_n = w_ascii;
                    w_out_last_n = FIRST_IS_LAST;
                end
            end

            S_DIGIT: begin
                if (w_fire) begin
                    if (r_idx != '0) begin
                        w_idx_n      = r_idx - IDX_W'(1);
                        w_word_n     = DATA_W'(r_word << 4);
                        w_out_char_n = w_ascii;
                        w_out_last_n = LAST_ON_DIGIT && (r_idx == IDX_W'(1));
                    end else if (TERM != 0) begin
                        w_state_n    = S_TERM;
                        w_out_char_n = CH_LF;
                        w_out_last_n = 1'b1;
                    end else begin
                        w_state_n     = S_IDLE;
                        w_out_valid_n = 1'b0;
                        w_out_char_n  = 7'h00;
                        w_out_last_n  = 1'b0;
                    end
                end
            end

            S_TERM: begin
                if (w_fire) begin
                    w_state_n     = S_IDLE;
                    w_out_valid_n = 1'b0;
                    w_out_char_n  = 7'h00;
                    w_out_last_n  = 1'b0;
                end
            end

            default: begin
                w_state_n     = S_IDLE;
                w_out_valid_n = 1'b0;
                w_out_char_n  = 7'h00;
                w_out_last_n  = 1'b0;
            end
        endcase

        // Handshake flags follow the state being entered.
        w_in_ready_n = (w_state_n == S_IDLE);
        w_busy_n     = (w_state_n != S_IDLE);
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_char  = r_out_char;
    assign out_last  = r_out_last;
    assign busy      = r_busy;

endmodule

// File: tb/tb_hex_word_printer.sv
// ----------------------------------------------------------------------------
// tb_hex_word_printer
//   Checks hex_word_printer in two configurations: the default 8-nibble
//   word with "0x" prefix and '\n' terminator, and a bare single-nibble
//   printer. Expected character streams come from a queue-based model
//   built directly from the printing rules.
// ----------------------------------------------------------------------------
module tb_hex_word_printer;

    logic        clk;
    logic        rst;

    logic        a_in_valid;
    logic        a_in_ready;
    logic [31:0] a_in_data;
    logic        a_out_valid;
    logic        a_out_ready;
    logic [6:0]  a_out_char;
    logic        a_out_last;
    logic        a_busy;

    logic        b_in_valid;
    logic        b_in_ready;
    logic [3:0]  b_in_data;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [6:0]  b_out_char;
    logic        b_out_last;
    logic        b_busy;

    int n_vec;
    int n_err;
    int exp_q[$];

    hex_word_printer #(.NIBBLES(8), .PREFIX(1), .TERM(1)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_char  (a_out_char),
        .out_last  (a_out_last),
        .busy      (a_busy)
    );

    hex_word_printer #(.NIBBLES(1), .PREFIX(0), .TERM(0)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_char  (b_out_char),
        .out_last  (b_out_last),
        .busy      (b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int hex_char(input int h);
        return (h < 10) ? (48 + h) : (55 + h);
    endfunction

    // Expected stream for one 32-bit word: "0x" + 8 digits + '\n'.
    function automatic void model(input logic [31:0] w);
        exp_q.delete();
        exp_q.push_back(48);
        exp_q.push_back(120);
        for (int i = 7; i >= 0; i--) begin
            exp_q.push_back(hex_char(int'((w >> (4 * i)) & 32'hF)));
        end
        exp_q.push_back(10);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: sink always ready; 1: random stalls; 2: 3-cycle stall on 'x'.
    // stop_after >= 0 abandons the word after that many characters.
    task automatic run_word(input logic [31:0] w, input int mode, input bit poke,
                            input int stop_after);
        int budget;
        int popped;
        int hold;
        bit rdy;
        model(w);
        budget = 0;
        while (!a_in_ready && budget < 20) begin
            tick();
            budget++;
        end
        check("in_ready_before_accept", a_in_ready, 1);
        a_in_valid = 1'b1;
        a_in_data  = w;
        tick();
        a_in_valid = 1'b0;
        a_in_data  = 32'h12345678;
        check("busy_after_accept", a_busy, 1);
        check("in_ready_after_accept", a_in_ready, 0);
        popped = 0;
        hold   = 0;
        budget = 0;
        while (exp_q.size() > 0 && popped != stop_after && budget < 400) begin
            check("out_valid", a_out_valid, 1);
            check("out_char", a_out_char, exp_q[0]);
            check("out_last", a_out_last, exp_q.size() == 1);
            check("in_ready_busy", a_in_ready, 0);
            case (mode)
                0: rdy = 1'b1;
                1: rdy = ($urandom_range(0, 2) != 0);
                default: begin
                    if (popped == 1 && hold < 3) begin
                        rdy = 1'b0;
                        hold++;
                    end else begin
                        rdy = 1'b1;
                    end
                end
            endcase
            a_out_ready = rdy;
            a_in_valid  = poke && (exp_q.size() > 1) && ($urandom_range(0, 1) == 1);
            tick();
            budget++;
            if (rdy) begin
                void'(exp_q.pop_front());
                popped++;
            end
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        if (stop_after < 0) begin
            check("word_complete", exp_q.size(), 0);
            check("out_valid_after_word", a_out_valid, 0);
            check("in_ready_after_word", a_in_ready, 1);
            check("busy_after_word", a_busy, 0);
        end
    endtask

    initial begin
        logic [3:0] nibs[8];
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        a_in_valid = 1'b0;
        a_in_data = '0;
        a_out_ready = 1'b1;
        b_in_valid = 1'b0;
        b_in_data = '0;
        b_out_ready = 1'b1;
        tick();
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_out_valid", a_out_valid, 0);
        check("rst_out_last", a_out_last, 0);
        check("rst_busy", a_busy, 0);
        check("rst_out_char", a_out_char, 0);
        check("rst_in_ready", a_in_ready, 1);
        check("rst_b_in_ready", b_in_ready, 1);

        // Plain DEADBEEF, then digit coverage
        run_word(32'hDEADBEEF, 0, 1'b0, -1);
        run_word(32'h01234567, 0, 1'b0, -1);
        run_word(32'h89ABCDEF, 0, 1'b0, -1);

        // Backpressure on the 'x' beat
        run_word(32'hDEADBEEF, 2, 1'b0, -1);

        // in_valid pulses while busy must be ignored
        run_word(32'hDEADBEEF, 0, 1'b1, -1);

        // Reset after five characters
        run_word(32'hDEADBEEF, 0, 1'b0, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_out_valid", a_out_valid, 0);
        check("midrst_busy", a_busy, 0);
        check("midrst_in_ready", a_in_ready, 1);
        check("midrst_out_last", a_out_last, 0);

        // Reset wins over a simultaneous in_valid
        rst = 1'b1;
        a_in_valid = 1'b1;
        a_in_data = 32'hCAFEF00D;
        tick();
        rst = 1'b0;
        a_in_valid = 1'b0;
        check("rst_vs_valid_busy", a_busy, 0);
        check("rst_vs_valid_out_valid", a_out_valid, 0);
        tick();
        check("rst_vs_valid_no_accept", a_out_valid, 0);

        run_word(32'h0000000F, 0, 1'b0, -1);

        // Random words under random backpressure and busy-time pokes
        for (int k = 0; k < 25; k++) begin
            run_word($urandom, 1, bit'($urandom_range(0, 1)), -1);
        end

        // Single-nibble printer: one char per word, accept every 2 cycles
        nibs[0] = 4'hA;
        for (int k = 1; k < 8; k++) nibs[k] = 4'($urandom);
        b_in_data  = nibs[0];
        b_in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("b_out_valid", b_out_valid, 1);
            check("b_out_char", b_out_char, hex_char(int'(nibs[k])));
            check("b_out_last", b_out_last, 1);
            check("b_in_ready_busy", b_in_ready, 0);
            b_in_data = nibs[(k + 1) % 8];
            tick();
            check("b_idle_out_valid", b_out_valid, 0);
            check("b_idle_in_ready", b_in_ready, 1);
        end
        b_in_valid = 1'b0;
        tick();
        check("b_final_idle", b_busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
